// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb and handshakes
// with instruction memory, data memory and the mul/div unit.
module multicycle_control #(
  parameter bit EN_MEXT     = 1'b0,
  parameter int MEM_TIMEOUT = 0,
  parameter bit TRAP_HALT   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       mdu_done,
  input  logic       branch_taken,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       mdu_start,
  output logic [2:0] mdu_op,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       memory_to_reg,
  output logic       alu_src,
  output logic [3:0] alu_opcode,
  output logic [1:0] pc_src,
  output logic       illegal_instr,
  output logic       bus_error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3,
    WB = 3'd4, MDU_WAIT = 3'd5, TRAP = 3'd6
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6;
  localparam logic [1:0] PC_PLUS4 = 2'd0, PC_BR = 2'd1, PC_JAL = 2'd2, PC_JALR = 2'd3;
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t          st;
  logic [CW-1:0]   cnt, cnt_inc;
  logic            ill_q, berr_q;
  logic            is_r, is_imm, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_mext;
  logic            f3_ok, legal, mem_to;
  logic [3:0]      alu_f3;

  assign is_r    = opcode == 7'b0110011;
  assign is_imm  = opcode == 7'b0010011;
  assign is_ld   = opcode == 7'b0000011;
  assign is_st   = opcode == 7'b0100011;
  assign is_br   = opcode == 7'b1100011;
  assign is_jal  = opcode == 7'b1101111;
  assign is_jalr = opcode == 7'b1100111;
  assign is_lui  = opcode == 7'b0110111;
  assign is_mext = is_r && func7 == 7'b0000001;

  // Shift func3 encodings (001/101) are outside the legal set.
  assign f3_ok = func3 != 3'b001 && func3 != 3'b101;
  assign legal = (is_r && ((func7 == 7'b0000000 && f3_ok) ||
                           (func7 == 7'b0100000 && func3 == 3'b000) ||
                           (is_mext && EN_MEXT))) ||
                 (is_imm && f3_ok) ||
                 ((is_ld || is_st) && func3 == 3'b010) ||
                 (is_br && func3 != 3'b010 && func3 != 3'b011) ||
                 is_jal || (is_jalr && func3 == 3'b000) || is_lui;

  always_comb begin
    alu_f3 = ALU_ADD;
    case (func3)
      3'b000:  alu_f3 = (is_r && func7[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_f3 = ALU_AND;
      3'b110:  alu_f3 = ALU_OR;
      3'b100:  alu_f3 = ALU_XOR;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      default: alu_f3 = ALU_ADD;
    endcase
  end

  assign cnt_inc = cnt + CW'(1);
  // A ready strobe on the cycle the limit is reached still completes the access.
  assign mem_to  = (MEM_TIMEOUT != 0) && !dmem_ready && (cnt_inc == CW'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= FETCH;
      cnt    <= '0;
      ill_q  <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      case (st)
        FETCH:    if (imem_ready) st <= DECODE;
        DECODE:   if (!legal) begin st <= TRAP; ill_q <= 1'b1; end
                  else st <= EXEC;
        EXEC: begin
          cnt <= '0;
          if (is_br)                st <= FETCH;
          else if (is_ld || is_st)  st <= MEM;
          else if (is_mext)         st <= MDU_WAIT;
          else                      st <= WB;
        end
        MEM: begin
          if (dmem_ready)  st <= is_st ? FETCH : WB;
          else if (mem_to) begin st <= TRAP; berr_q <= 1'b1; end
          else             cnt <= cnt_inc;
        end
        MDU_WAIT: if (mdu_done) st <= WB;
        WB:       st <= FETCH;
        TRAP:     if (!TRAP_HALT) begin st <= FETCH; ill_q <= 1'b0; berr_q <= 1'b0; end
        default:  st <= FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    mdu_start     = 1'b0;
    mdu_op        = 3'd0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    memory_to_reg = 1'b0;
    alu_src       = 1'b0;
    alu_opcode    = ALU_ADD;
    pc_src        = PC_PLUS4;
    case (st)
      FETCH: begin
        imem_req = rst_n;
        ir_write = rst_n && imem_ready;
      end
      EXEC: begin
        alu_src = is_imm || is_ld || is_st || is_jal || is_jalr || is_lui;
        if (is_br) begin
          alu_opcode = (func3[2:1] == 2'b00) ? ALU_SUB :
                       (func3[2:1] == 2'b10) ? ALU_SLT : ALU_SLTU;
          pc_write   = 1'b1;
          pc_src     = branch_taken ? PC_BR : PC_PLUS4;
        end else if (is_mext) begin
          mdu_start = 1'b1;
          mdu_op    = func3;
        end else if (is_r || is_imm) begin
          alu_opcode = alu_f3;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_st;
        alu_src  = 1'b1;
        pc_write = dmem_ready && is_st;
      end
      MDU_WAIT: mdu_op = func3;
      WB: begin
        reg_write     = 1'b1;
        pc_write      = 1'b1;
        memory_to_reg = is_ld;
        pc_src        = is_jal ? PC_JAL : is_jalr ? PC_JALR : PC_PLUS4;
      end
      TRAP: pc_write = !TRAP_HALT;
      default: ;
    endcase
  end

  assign illegal_instr = ill_q;
  assign bus_error     = berr_q;
  assign state         = st;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: two configurations share stimulus,
// [0] = no M-ext, 5-cycle timeout, halting trap; [1] = M-ext, no timeout, skipping trap.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic imem_ready, dmem_ready, mdu_done, branch_taken;
  logic [1:0] imem_req, dmem_req, dmem_we, mdu_start, ir_write, pc_write, reg_write;
  logic [1:0] memory_to_reg, alu_src, illegal_instr, bus_error;
  logic [1:0][2:0] mdu_op, state;
  logic [1:0][3:0] alu_opcode;
  logic [1:0][1:0] pc_src;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    multicycle_control #(
      .EN_MEXT(g == 1), .MEM_TIMEOUT(g == 0 ? 5 : 0), .TRAP_HALT(g == 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .mdu_done(mdu_done),
      .branch_taken(branch_taken), .imem_req(imem_req[g]), .dmem_req(dmem_req[g]),
      .dmem_we(dmem_we[g]), .mdu_start(mdu_start[g]), .mdu_op(mdu_op[g]),
      .ir_write(ir_write[g]), .pc_write(pc_write[g]), .reg_write(reg_write[g]),
      .memory_to_reg(memory_to_reg[g]), .alu_src(alu_src[g]), .alu_opcode(alu_opcode[g]),
      .pc_src(pc_src[g]), .illegal_instr(illegal_instr[g]), .bus_error(bus_error[g]),
      .state(state[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk); endtask

  // Leaves the bench one step after a rising edge with rst_n just released: cycle 1.
  task automatic reset_dut();
    rst_n = 1'b0;
    imem_ready = 0; dmem_ready = 0; mdu_done = 0; branch_taken = 0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Runs FETCH (zero-wait) and DECODE; returns at the start of cycle 3.
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; func3 = f3; func7 = f7;
    imem_ready = 1'b1;
    smp();
    chk("fetch_state", state[1], 0);
    chk("fetch_irw", ir_write[1], 1);
    tick();
    imem_ready = 1'b0;
    smp();
    chk("decode_state", state[1], 1);
    chk("decode_imem", imem_req[1], 0);
    tick();
  endtask

  initial begin
    opcode = 0; func3 = 0; func7 = 0;
    imem_ready = 1; dmem_ready = 1; mdu_done = 1; branch_taken = 1;
    smp();
    chk("rst_state", state, 0);
    chk("rst_imem", imem_req, 0);
    chk("rst_irw", ir_write, 0);
    chk("rst_pcw", pc_write, 0);
    chk("rst_dreq", dmem_req, 0);

    // ADD x3,x1,x2
    reset_dut();
    instr(7'b0110011, 3'b000, 7'b0000000);
    smp();
    chk("add_exec_state", state[1], 2);
    chk("add_alu", alu_opcode[1], 0);
    chk("add_src", alu_src[1], 0);
    chk("add_exec_pcw", pc_write[1], 0);
    tick(); smp();
    chk("add_wb_state", state[1], 4);
    chk("add_wb_rw", reg_write[1], 1);
    chk("add_wb_pcw", pc_write[1], 1);
    chk("add_wb_pcsrc", pc_src[1], 0);
    tick(); smp();
    chk("add_done", state[1], 0);

    // SUB
    reset_dut();
    instr(7'b0110011, 3'b000, 7'b0100000);
    smp();
    chk("sub_alu", alu_opcode[1], 1);

    // BLTU taken
    reset_dut();
    instr(7'b1100011, 3'b110, 7'b0000000);
    branch_taken = 1'b1;
    smp();
    chk("bltu_alu", alu_opcode[1], 6);
    chk("bltu_pcw", pc_write[1], 1);
    chk("bltu_pcsrc", pc_src[1], 1);
    chk("bltu_rw", reg_write[1], 0);
    tick(); branch_taken = 1'b0; smp();
    chk("bltu_done", state[1], 0);

    // BLT not taken
    reset_dut();
    instr(7'b1100011, 3'b100, 7'b0000000);
    smp();
    chk("blt_alu", alu_opcode[1], 5);
    chk("blt_pcsrc", pc_src[1], 0);
    chk("blt_pcw", pc_write[1], 1);

    // LW with dmem_ready on the fourth MEM cycle
    reset_dut();
    instr(7'b0000011, 3'b010, 7'b0000000);
    smp();
    chk("lw_exec_src", alu_src[1], 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      smp();
      chk("lw_mem_state", state[1], 3);
      chk("lw_dreq", dmem_req[1], 1);
      chk("lw_dwe", dmem_we[1], 0);
      tick();
    end
    dmem_ready = 1'b0;
    smp();
    chk("lw_wb_state", state[1], 4);
    chk("lw_m2r", memory_to_reg[1], 1);
    chk("lw_wb_rw", reg_write[1], 1);
    chk("lw_wb_pcw", pc_write[1], 1);
    tick(); smp();
    chk("lw_done", state[1], 0);

    // SW timeout on [0]
    reset_dut();
    instr(7'b0100011, 3'b010, 7'b0000000);
    tick();
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("swto_mem_state", state[0], 3);
      chk("swto_dwe", dmem_we[0], 1);
      chk("swto_berr_early", bus_error[0], 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("swto_trap_state", state[0], 6);
      chk("swto_berr", bus_error[0], 1);
      chk("swto_imem", imem_req[0], 0);
      chk("swto_pcw", pc_write[0], 0);
      tick();
    end

    // SW on [0] with dmem_ready exactly on the limit cycle
    reset_dut();
    instr(7'b0100011, 3'b010, 7'b0000000);
    tick(); tick(); tick(); tick(); tick();
    dmem_ready = 1'b1;
    smp();
    chk("swlim_state", state[0], 3);
    chk("swlim_pcw", pc_write[0], 1);
    tick(); dmem_ready = 1'b0; smp();
    chk("swlim_next", state[0], 0);
    chk("swlim_berr", bus_error[0], 0);

    // MUL: [0] traps, [1] runs the MDU handshake
    reset_dut();
    instr(7'b0110011, 3'b000, 7'b0000001);
    mdu_done = 1'b1;
    smp();
    chk("mul0_trap", state[0], 6);
    chk("mul0_ill", illegal_instr[0], 1);
    chk("mul1_exec", state[1], 2);
    chk("mul1_start", mdu_start[1], 1);
    chk("mul1_op", mdu_op[1], 0);
    tick(); mdu_done = 1'b0; smp();
    chk("mul1_wait", state[1], 5);
    chk("mul1_start_off", mdu_start[1], 0);
    tick(); smp(); tick();
    mdu_done = 1'b1;
    smp();
    chk("mul1_wait2", state[1], 5);
    tick(); mdu_done = 1'b0; smp();
    chk("mul1_wb", state[1], 4);
    chk("mul1_rw", reg_write[1], 1);
    chk("mul0_hold", state[0], 6);
    chk("mul0_imem", imem_req[0], 0);
    tick(); smp();
    chk("mul1_done", state[1], 0);

    // SLLI on [1]: one-cycle skip
    reset_dut();
    instr(7'b0010011, 3'b001, 7'b0000000);
    smp();
    chk("slli_state", state[1], 6);
    chk("slli_ill", illegal_instr[1], 1);
    chk("slli_pcw", pc_write[1], 1);
    chk("slli_pcsrc", pc_src[1], 0);
    tick(); smp();
    chk("slli_back", state[1], 0);
    chk("slli_ill_off", illegal_instr[1], 0);
    chk("slli_imem", imem_req[1], 1);

    // JAL / JALR writeback selects
    reset_dut();
    instr(7'b1101111, 3'b000, 7'b0000000);
    tick(); smp();
    chk("jal_pcsrc", pc_src[1], 2);
    chk("jal_rw", reg_write[1], 1);
    reset_dut();
    instr(7'b1100111, 3'b000, 7'b0000000);
    tick(); smp();
    chk("jalr_pcsrc", pc_src[1], 3);

    // Reset pulsed mid-MEM
    reset_dut();
    instr(7'b0000011, 3'b010, 7'b0000000);
    tick(); smp();
    chk("rmid_mem", state[1], 3);
    rst_n = 1'b0;
    #1;
    chk("rmid_state", state, 0);
    chk("rmid_dreq", dmem_req, 0);
    chk("rmid_imem", imem_req, 0);
    tick();
    rst_n = 1'b1;
    smp();
    chk("rmid_refetch", imem_req[1], 1);
    chk("rmid_no_dreq", dmem_req[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
